cac_decoder_5: RTL
==================

# cac_decoder_5

Iterative decoder for the 5-wire Fibonacci-numeral-system (FNS) crosstalk-avoidance code on the receive side of a link. It accepts one 5-bit codeword over a valid/ready handshake. It reconstructs the binary data word as the weighted sum of the codeword bits, processing one bit per cycle from MSB to LSB. It returns the word over a second valid/ready handshake, plus a range-error flag for codewords whose value does not fit the data width.

## Interface
- DW, 4: data word width; matches `BLEN_05`.
- FW, 4: width of each FNS weight input; matches `FNSLEN_05`.
- clock  in  1  rising-edge clock for all state.
- reset_n  in  1  synchronous, active-low reset, sampled on the rising edge of clock.
- codein  in  5  received codeword; bit 4 is the MSB.
- in_valid  in  1  codein and the weights are valid.
- in_ready  out  1  decoder can accept a codeword.
- FNS02, FNS03, FNS04, FNS05  in  FW each  weights of codein bits 1, 2, 3 and 4. Bit 0 has a fixed weight of 1.
- dataout  out  DW  decoded word, taken modulo 2^DW.
- err  out  1  the decoded sum is ≥ 2^DW; qualified by out_valid.
- out_valid  out  1  dataout and err are valid.
- out_ready  in  1  downstream accepts the result.

## Operation
- The state machine has three states: IDLE, ACC and DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready, latch codein and all four weights into local registers.
  - Clear the accumulator and set bit index idx = 4. Go to ACC.
- ACC:
  - in_ready = 0 and out_valid = 0.
  - Each cycle, add w[idx] to the accumulator if cw[idx] = 1, where w[4..1] = FNS05..FNS02 and w[0] = 1.
  - Decrement idx. After bit 0 is processed, go to DONE.
  - ACC lasts exactly 5 cycles.
- Accumulator width is DW+3 bits. This cannot wrap: the maximum sum 4·(2^FW−1)+1 fits when FW ≤ DW.
- DONE:
  - out_valid = 1, dataout = acc[DW-1:0], err = (acc ≥ 2^DW).
  - Outputs hold stable until out_valid && out_ready, then go to IDLE.
  - in_ready = 0 throughout DONE.
- Weights are sampled only at accept. Changes to FNSxx or codein after accept have no effect on the transaction in flight.
- A codeword of all zeros still takes the full 5 ACC cycles and produces dataout = 0, err = 0.
- No codeword validity check beyond range is performed. A codeword with forbidden patterns decodes by plain weighted sum.
- The block is the inverse of the FNS encoder: for any codeword the encoder emits from input d, the result is dataout = d and err = 0.

## Timing
- Reset (reset_n = 0 at a rising edge) forces:
  - state = IDLE, in_ready = 1, out_valid = 0, dataout = 0, err = 0, accumulator = 0, idx = 4.
  - This applies in any state, including mid-ACC and DONE with a pending result. A pending result is discarded.
- in_ready and out_valid are registered and decoded from state only. Neither is combinationally dependent on in_valid or out_ready.
- Latency: accept edge E0 → ACC edges E1..E5 → out_valid is high after E5, i.e. 6 cycles from accept.
- Minimum throughput is one codeword per 7 cycles: accept, 5 × ACC, and 1 × DONE with out_ready = 1.
- When out_ready is held 0, DONE persists indefinitely. dataout and err stay constant and in_valid is ignored.
- The DONE→IDLE handshake and a new accept cannot occur on the same edge. A new accept is earliest on the edge after the return to IDLE.
- in_valid asserted while in_ready = 0 is ignored. The upstream side must hold its data until it sees in_ready.

## Test plan
- Weights FNS05=8, FNS04=5, FNS03=3, FNS02=2; codein = 5'b10100 → after 6 cycles dataout = 11, err = 0, out_valid = 1.
- Same weights; codein = 5'b11111 → sum = 19, so dataout = 3, err = 1.
- Same weights; codein = 5'b00000 → dataout = 0, err = 0, latency still 6 cycles; then codein = 5'b00001 → dataout = 1.
- Hold out_ready = 0 for 10 cycles in DONE while in_valid = 1 with new data → dataout and err are stable, in_ready = 0, no second accept. Release out_ready → the next accept occurs in IDLE.
- Assert reset_n = 0 during the 3rd ACC cycle → next cycle shows IDLE, in_ready = 1, out_valid = 0, dataout = 0. A following codein = 5'b01010 decodes to 7.
- Change FNS05 from 8 to 13 one cycle after accepting codein = 5'b10000 → dataout = 8. Then run all 5-bit codewords against a reference sum → every result matches, including err.

Source files
------------

// File: rtl/cac_decoder_5.sv
// cac_decoder_5: iterative decoder for the 5-wire Fibonacci-numeral-system
// crosstalk-avoidance code. A codeword and its four weights are latched on
// accept. The weighted sum is then accumulated one bit per cycle, MSB first,
// over exactly five cycles. The result is held in DONE until downstream takes it.
module cac_decoder_5 #(
   parameter int DW = 4,
   parameter int FW = 4
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic [4:0]    codein,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [FW-1:0] FNS02,
   input  logic [FW-1:0] FNS03,
   input  logic [FW-1:0] FNS04,
   input  logic [FW-1:0] FNS05,
   output logic [DW-1:0] dataout,
   output logic          err,
   output logic          out_valid,
   input  logic          out_ready
);

   // The accumulator has three guard bits above the data width. The largest
   // sum, 4*(2^FW-1)+1, therefore always fits when FW <= DW, and the range
   // check can look at the guard bits alone.
   localparam int AW = DW + 3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACC  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t          state_q;
   logic [4:0]      cw_q;
   logic [FW-1:0]   w2_q;
   logic [FW-1:0]   w3_q;
   logic [FW-1:0]   w4_q;
   logic [FW-1:0]   w5_q;
   logic [AW-1:0]   acc_q;
   logic [2:0]      idx_q;
   logic            in_ready_q;
   logic            out_valid_q;
   logic [DW-1:0]   dataout_q;
   logic            err_q;

   logic [AW-1:0]   term_d;
   logic [AW-1:0]   acc_d;
   logic [DW-1:0]   dataout_d;
   logic            err_d;

   // Widen an FW-bit weight into the accumulator width.
   function automatic logic [AW-1:0] widen(input logic [FW-1:0] w);
      logic [AW-1:0] r;
      r         = '0;
      r[FW-1:0] = w;
      return r;
   endfunction

   // Return the contribution of codeword bit idx: its weight if the bit is
   // set, and zero otherwise. Bit 0 always weighs 1.
   function automatic logic [AW-1:0] bit_term(
      input logic [4:0]    cw,
      input logic [2:0]    idx,
      input logic [FW-1:0] w2,
      input logic [FW-1:0] w3,
      input logic [FW-1:0] w4,
      input logic [FW-1:0] w5
   );
      logic [AW-1:0] w;
      logic          b;
      case (idx)
         3'd4: begin w = widen(w5); b = cw[4]; end
         3'd3: begin w = widen(w4); b = cw[3]; end
         3'd2: begin w = widen(w3); b = cw[2]; end
         3'd1: begin w = widen(w2); b = cw[1]; end
         3'd0: begin w = {{(AW-1){1'b0}}, 1'b1}; b = cw[0]; end
         default: begin w = '0; b = 1'b0; end
      endcase
      if (b) begin
         return w;
      end else begin
         return '0;
      end
   endfunction

   // Compute the next accumulator value for the bit now being processed,
   // along with the truncated word and the range flag for the final step.
   always_comb begin
      term_d    = bit_term(cw_q, idx_q, w2_q, w3_q, w4_q, w5_q);
      acc_d     = acc_q + term_d;
      dataout_d = acc_d[DW-1:0];
      err_d     = |acc_d[AW-1:DW];
   end

   // Decoder FSM. in_ready and out_valid are registered and depend on state
   // only, so they never combinationally follow in_valid or out_ready.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         cw_q        <= 5'd0;
         w2_q        <= '0;
         w3_q        <= '0;
         w4_q        <= '0;
         w5_q        <= '0;
         acc_q       <= '0;
         idx_q       <= 3'd4;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         dataout_q   <= '0;
         err_q       <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (in_valid && in_ready_q) begin
                  cw_q       <= codein;
                  w2_q       <= FNS02;
                  w3_q       <= FNS03;
                  w4_q       <= FNS04;
                  w5_q       <= FNS05;
                  acc_q      <= '0;
                  idx_q      <= 3'd4;
                  in_ready_q <= 1'b0;
                  state_q    <= ST_ACC;
               end else begin
                  in_ready_q <= 1'b1;
               end
            end
            ST_ACC: begin
               acc_q <= acc_d;
               if (idx_q == 3'd0) begin
                  dataout_q   <= dataout_d;
                  err_q       <= err_d;
                  out_valid_q <= 1'b1;
                  state_q     <= ST_DONE;
               end else begin
                  idx_q <= idx_q - 3'd1;
               end
            end
            ST_DONE: begin
               // The result stays put until it is taken. A new accept can
               // only happen on a later edge, from IDLE.
               if (out_valid_q && out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  idx_q       <= 3'd4;
                  state_q     <= ST_IDLE;
               end else begin
                  out_valid_q <= 1'b1;
               end
            end
            default: begin
               // An unreachable encoding recovers to a clean idle.
               state_q     <= ST_IDLE;
               acc_q       <= '0;
               idx_q       <= 3'd4;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign dataout   = dataout_q;
   assign err       = err_q;

endmodule
